register_bank_param: RTL

Parametrised successor to the two-read/one-write register bank. It supports configurable width, address depth and an optional hardwired-zero entry 0. Both read ports are registered and have 1-cycle latency. A sequencer clears the array after reset or on request, and the bank signals ready only once the array is clean. It sits between decode (read addresses) and writeback (write port) in the datapath.

---
 rtl/register_bank_param.sv | 128 ++++++++++++
 1 files changed

// File: rtl/register_bank_param.sv
// Two-read/one-write register bank with registered reads and a clear walk.
// Optional write-first forwarding is enabled by defining REGBANK_BYPASS_EN.
module register_bank_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic              clearReq,
  output logic [DATA_W-1:0] RegData1,
  output logic [DATA_W-1:0] RegData2,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_run;
  logic              w_we;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_run = (r_state == RUN);
  assign ready = w_run;

  // A clear request wins over a write issued in the same cycle.
  assign w_we = w_run && regWrite && !clearReq &&
                !(ZR && (writeReg == '0));

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    unique case (r_state)
      CLEAR: begin
        if (r_clr_addr == '1) begin
          w_state_nxt    = RUN;
          w_clr_addr_nxt = '0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
        end
      end
      RUN: begin
        if (clearReq) begin
          w_state_nxt    = CLEAR;
          w_clr_addr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = CLEAR;
        w_clr_addr_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // Contents are left alone by reset; the walk zeroes them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!w_run) begin
        r_mem[r_clr_addr] <= '0;
      end else if (w_we) begin
        r_mem[writeReg] <= writeData;
      end
    end
  end

  always_comb begin
    w_rd1 = r_mem[readReg1];
    if (ZR && (readReg1 == '0)) begin
      w_rd1 = '0;
    end
`ifdef REGBANK_BYPASS_EN
    if (w_we && (writeReg == readReg1)) begin
      w_rd1 = writeData;
    end
`endif
  end

  always_comb begin
    w_rd2 = r_mem[readReg2];
    if (ZR && (readReg2 == '0)) begin
      w_rd2 = '0;
    end
`ifdef REGBANK_BYPASS_EN
    if (w_we && (writeReg == readReg2)) begin
      w_rd2 = writeData;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !w_run) begin
      RegData1 <= '0;
      RegData2 <= '0;
    end else begin
      RegData1 <= w_rd1;
      RegData2 <= w_rd2;
    end
  end

endmodule
